// File: rtl/ram_queue_ctrl.sv
// Circular-queue controller for the single-port 8-bit sample RAM: sequences writes and drains oldest-first.
// Build option QUEUE_OVERWRITE_EN: a write into a full queue replaces the oldest sample instead of being dropped.
module ram_queue_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic [7:0]      smpl,
  input  logic            start_rd,
  output logic            ram_we,
  output logic [LOG2-1:0] ram_waddr,
  output logic [LOG2-1:0] ram_raddr,
  output logic [7:0]      ram_wdata,
  input  logic [7:0]      ram_rdata,
  output logic            rd_valid,
  output logic [7:0]      rd_data,
  output logic            rd_done,
  output logic            busy,
  output logic            full,
  output logic [LOG2-1:0] cnt,
  output logic            ovr
);

  // state | meaning
  // IDLE  | accept samples; start_rd launches a drain (or an immediate rd_done when empty)
  // READ  | issue one RAM read per cycle from rd_ptr; remaining counts down to the last issue
  // DRAIN | last read data returns with rd_done; queue is then emptied
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE  = LOG2'(1);

  state_t          state, state_nxt;
  logic [LOG2-1:0] new_ptr, new_ptr_nxt;
  logic [LOG2-1:0] old_ptr, old_ptr_nxt;
  logic [LOG2-1:0] rd_ptr, rd_ptr_nxt;
  logic [LOG2-1:0] remaining, remaining_nxt;
  logic [LOG2-1:0] cnt_nxt;
  logic            ovr_nxt;
  logic            rd_valid_nxt;
  logic            done_empty, done_empty_nxt;

  // ENTRIES need not be a power of two, so wrap explicitly
  function automatic logic [LOG2-1:0] ptr_inc(input logic [LOG2-1:0] p);
    return (p == LAST) ? '0 : p + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      remaining  <= '0;
      cnt        <= '0;
      full       <= 1'b0;
      ovr        <= 1'b0;
      rd_valid   <= 1'b0;
      done_empty <= 1'b0;
    end else begin
      state      <= state_nxt;
      new_ptr    <= new_ptr_nxt;
      old_ptr    <= old_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      remaining  <= remaining_nxt;
      cnt        <= cnt_nxt;
      full       <= (cnt_nxt == LAST);
      ovr        <= ovr_nxt;
      rd_valid   <= rd_valid_nxt;
      done_empty <= done_empty_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    new_ptr_nxt    = new_ptr;
    old_ptr_nxt    = old_ptr;
    rd_ptr_nxt     = rd_ptr;
    remaining_nxt  = remaining;
    cnt_nxt        = cnt;
    ovr_nxt        = ovr;
    rd_valid_nxt   = 1'b0;
    done_empty_nxt = 1'b0;
    ram_we         = 1'b0;

    unique case (state)
      IDLE: begin
        if (wrt_smpl) begin
          if (!full) begin
            ram_we      = 1'b1;
            new_ptr_nxt = ptr_inc(new_ptr);
            cnt_nxt     = cnt + ONE;
          end else begin
`ifdef QUEUE_OVERWRITE_EN
            ram_we      = 1'b1;
            new_ptr_nxt = ptr_inc(new_ptr);
            old_ptr_nxt = ptr_inc(old_ptr);
`endif
            ovr_nxt = 1'b1;
          end
        end else if (start_rd) begin
          if (cnt != '0) begin
            state_nxt     = READ;
            rd_ptr_nxt    = old_ptr;
            remaining_nxt = cnt;
            ovr_nxt       = 1'b0;
          end else begin
            done_empty_nxt = 1'b1;
          end
        end
      end

      READ: begin
        rd_valid_nxt  = 1'b1;
        rd_ptr_nxt    = ptr_inc(rd_ptr);
        remaining_nxt = remaining - ONE;
        if (remaining == ONE) state_nxt = DRAIN;
        if (wrt_smpl) ovr_nxt = 1'b1;
      end

      DRAIN: begin
        old_ptr_nxt = new_ptr;
        cnt_nxt     = '0;
        state_nxt   = IDLE;
        if (wrt_smpl) ovr_nxt = 1'b1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // the read address is only consumed while ram_we is low, so it can follow rd_ptr freely
  assign ram_waddr = new_ptr;
  assign ram_raddr = rd_ptr;
  assign ram_wdata = ram_we ? smpl : 8'h00;
  assign rd_data   = rd_valid ? ram_rdata : 8'h00;
  assign rd_done   = (state == DRAIN) | done_empty;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Self-checking bench for ram_queue_ctrl: directed scenarios plus random rounds against a queue-based model.
module tb_ram_queue_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wrt_smpl = 1'b0;
  logic [7:0]      smpl = 8'h00;
  logic            start_rd = 1'b0;
  logic            ram_we;
  logic [LOG2-1:0] ram_waddr;
  logic [LOG2-1:0] ram_raddr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata = 8'h00;
  logic            rd_valid;
  logic [7:0]      rd_data;
  logic            rd_done;
  logic            busy;
  logic            full;
  logic [LOG2-1:0] cnt;
  logic            ovr;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: queue contents, next write address, oldest address, overrun flag
  logic [7:0] q[$];
  int         wpos = 0;
  int         rpos = 0;
  bit         ovr_m = 1'b0;

  logic [7:0] mem [0:ENTRIES-1];

  ram_queue_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .smpl(smpl), .start_rd(start_rd),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .busy(busy), .full(full), .cnt(cnt), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    else        ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wpos  = 0;
    rpos  = 0;
    ovr_m = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(ram_we),    0);
    chk({tag, "_valid"}, 32'(rd_valid),  0);
    chk({tag, "_data"},  32'(rd_data),   0);
    chk({tag, "_done"},  32'(rd_done),   0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_full"},  32'(full),      0);
    chk({tag, "_cnt"},   32'(cnt),       0);
    chk({tag, "_ovr"},   32'(ovr),       0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 0);
    chk({tag, "_raddr"}, 32'(ram_raddr), 0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // one wrt_smpl cycle, starting and ending at a negedge
  task automatic do_write(input logic [7:0] d);
    bit fullm;
    fullm    = (q.size() == ENTRIES - 1);
    wrt_smpl = 1'b1;
    smpl     = d;
    #1;
    if (!fullm) begin
      chk("wr_we",    32'(ram_we),    1);
      chk("wr_waddr", 32'(ram_waddr), 32'(wpos));
      chk("wr_wdata", 32'(ram_wdata), 32'(d));
      q.push_back(d);
      wpos = (wpos + 1) % ENTRIES;
    end else begin
`ifdef QUEUE_OVERWRITE_EN
      chk("ovw_we",    32'(ram_we),    1);
      chk("ovw_waddr", 32'(ram_waddr), 32'(wpos));
      void'(q.pop_front());
      q.push_back(d);
      wpos = (wpos + 1) % ENTRIES;
      rpos = (rpos + 1) % ENTRIES;
`else
      chk("drop_we", 32'(ram_we), 0);
`endif
      ovr_m = 1'b1;
    end
    @(negedge clk);
    wrt_smpl = 1'b0;
    chk("wr_cnt",  32'(cnt),  32'(q.size()));
    chk("wr_full", 32'(full), 32'(q.size() == ENTRIES - 1));
    chk("wr_ovr",  32'(ovr),  32'(ovr_m));
  endtask

  // start_rd in cycle 0; wrt_smpl forced on cycles [inj_start, inj_start+inj_len)
  task automatic drain(input int inj_start, input int inj_len);
    logic [7:0] exp_q[$];
    int n, r0;
    exp_q    = q;
    n        = q.size();
    r0       = rpos;
    start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    if (n == 0) begin
      #1;
      chk("empty_done",  32'(rd_done),  1);
      chk("empty_valid", 32'(rd_valid), 0);
      chk("empty_busy",  32'(busy),     0);
      @(negedge clk);
      #1;
      chk("empty_done2", 32'(rd_done), 0);
      chk("empty_busy2", 32'(busy),    0);
      return;
    end
    ovr_m = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      if (c > 1) @(negedge clk);
      wrt_smpl = (c >= inj_start) && (c < inj_start + inj_len);
      smpl     = 8'($urandom);
      #1;
      chk("rd_busy", 32'(busy),   1);
      chk("rd_we",   32'(ram_we), 0);
      if (c == 1) chk("rd_ovr_clr", 32'(ovr), 0);
      if (c <= n) chk("rd_raddr", 32'(ram_raddr), 32'((r0 + c - 1) % ENTRIES));
      if (c >= 2) begin
        chk("rd_valid", 32'(rd_valid), 1);
        chk("rd_data",  32'(rd_data),  32'(exp_q[c-2]));
        chk("rd_done",  32'(rd_done),  32'(c == n + 1));
      end else begin
        chk("rd_valid0", 32'(rd_valid), 0);
        chk("rd_done0",  32'(rd_done),  0);
      end
      if (wrt_smpl) ovr_m = 1'b1;
    end
    @(negedge clk);
    wrt_smpl = 1'b0;
    q.delete();
    rpos = wpos;
    #1;
    chk("end_busy",  32'(busy),     0);
    chk("end_cnt",   32'(cnt),      0);
    chk("end_full",  32'(full),     0);
    chk("end_valid", 32'(rd_valid), 0);
    chk("end_done",  32'(rd_done),  0);
    chk("end_ovr",   32'(ovr),      32'(ovr_m));
  endtask

  initial begin
    int n, s, l;
    @(negedge clk);
    apply_reset();

    // empty drain: rd_done only
    drain(0, 0);

    // five samples 0x10..0x14
    for (int i = 0; i < 5; i++) do_write(8'(8'h10 + i));
    drain(0, 0);

    // fill to ENTRIES-1 then one more
    apply_reset();
    for (int i = 0; i < ENTRIES - 1; i++) do_write(8'(i));
    do_write(8'hAA);
    drain(0, 0);

    // wrap-around of both write and read addresses
    apply_reset();
    for (int i = 0; i < 300; i++) do_write(8'($urandom));
    drain(0, 0);
    for (int i = 0; i < 200; i++) do_write(8'($urandom));
    drain(0, 0);

    // simultaneous wrt_smpl and start_rd: write wins, read follows
    start_rd = 1'b1;
    do_write(8'h5A);
    chk("prio_busy", 32'(busy), 0);
    drain(0, 0);

    // writes during READ are discarded and set ovr; next drain clears it
    for (int i = 0; i < 10; i++) do_write(8'(8'h20 + i));
    drain(2, 3);
    do_write(8'h77);
    drain(0, 0);

    // reset in the middle of a drain
    for (int i = 0; i < 10; i++) do_write(8'(8'h30 + i));
    start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    @(negedge clk);
    #1 chk("mid_beat0", 32'(rd_data), 32'(q[0]));
    @(negedge clk);
    #1 chk("mid_beat1", 32'(rd_data), 32'(q[1]));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("mid_no_done", 32'(rd_done), 0);
    chk("mid_busy",    32'(busy),    0);
    @(negedge clk);
    drain(0, 0);

    // random rounds
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 420);
      for (int i = 0; i < n; i++) do_write(8'($urandom));
      if (q.size() == 0) begin
        drain(0, 0);
      end else begin
        s = $urandom_range(1, q.size() + 1);
        l = $urandom_range(0, 3);
        drain(s, l);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
